// File: rtl/rvfi_trace_pkg.sv
// Shared types and record layout for the RVFI retirement tracer.
package rvfi_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Trigger source selection.
  localparam logic [1:0] TRIG_TRAP   = 2'd0;
  localparam logic [1:0] TRIG_HALT   = 2'd1;
  localparam logic [1:0] TRIG_EITHER = 2'd2;
  localparam logic [1:0] TRIG_PC     = 2'd3;

  localparam int INSN_W = 32;

  // Record layout, LSB first:
  // pc_wdata | pc_rdata | insn | order | intr | halt | trap
  function automatic int rec_w(input int order_w, input int pc_w);
    return 3 + order_w + INSN_W + 2 * pc_w;
  endfunction

  function automatic int off_pc_wdata();
    return 0;
  endfunction

  function automatic int off_pc_rdata(input int pc_w);
    return pc_w;
  endfunction

  function automatic int off_insn(input int pc_w);
    return 2 * pc_w;
  endfunction

  function automatic int off_order(input int pc_w);
    return 2 * pc_w + INSN_W;
  endfunction

  function automatic int off_intr(input int order_w, input int pc_w);
    return 2 * pc_w + INSN_W + order_w;
  endfunction

  function automatic int off_halt(input int order_w, input int pc_w);
    return 2 * pc_w + INSN_W + order_w + 1;
  endfunction

  function automatic int off_trap(input int order_w, input int pc_w);
    return 2 * pc_w + INSN_W + order_w + 2;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port history memory: synchronous write, registered read with
// read enable so the output holds while the consumer stalls.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port.
  // NOTE: no reset on the array or its read register so the tool can map it
  // to block RAM; valid/ready state outside the RAM masks stale contents.
  // NOTE: non-blocking assignments in clocked blocks keep every register
  // sampling pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rvfi_trace_capture.sv
// RVFI retirement tracer: circular history, triggered freeze after a
// configurable number of further retirements, then oldest-first drain over a
// valid/ready stream. Also flags non-consecutive rvfi_order values.
module rvfi_trace_capture
  import rvfi_trace_pkg::*;
#(
  parameter  int DEPTH     = 64,
  parameter  int PC_W      = 32,
  parameter  int ORDER_W   = 16,
  parameter  int POST_TRIG = 8,
  localparam int REC_W     = rec_w(ORDER_W, PC_W)
) (
  input  logic             sys_clock,
  input  logic             reset,
  input  logic             rvfi_valid,
  input  logic [63:0]      rvfi_order,
  input  logic [31:0]      rvfi_insn,
  input  logic             rvfi_trap,
  input  logic             rvfi_halt,
  input  logic             rvfi_intr,
  input  logic [PC_W-1:0]  rvfi_pc_rdata,
  input  logic [PC_W-1:0]  rvfi_pc_wdata,
  input  logic             arm,
  input  logic [1:0]       trig_mode,
  input  logic [PC_W-1:0]  trig_pc,
  output logic [1:0]       state,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [REC_W-1:0] rd_data,
  output logic             rd_last,
  output logic             wrapped,
  output logic             order_gap
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

  typedef logic [AW-1:0] addr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] post_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  localparam int O_PCW   = off_pc_wdata();
  localparam int O_PCR   = off_pc_rdata(PC_W);
  localparam int O_INSN  = off_insn(PC_W);
  localparam int O_ORDER = off_order(PC_W);
  localparam int O_INTR  = off_intr(ORDER_W, PC_W);
  localparam int O_HALT  = off_halt(ORDER_W, PC_W);
  localparam int O_TRAP  = off_trap(ORDER_W, PC_W);

  state_e state_q, state_d;

  addr_t       wptr;
  cnt_t        count;
  cnt_t        issued;
  post_t       post_cnt;
  logic        prev_valid;
  logic [63:0] prev_order;
  logic        out_valid;
  logic        out_last;

  logic             capturing;
  logic             arm_restart;
  logic             wr_en;
  logic             trig_hit;
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] ram_rdata;
  cnt_t             remaining;
  addr_t            rd_addr;
  logic             rd_fire;
  logic             drain_done;

  // Capture-side control: arm restarts from IDLE/ARMED; writes only while capturing.
  assign capturing   = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign arm_restart = arm && ((state_q == ST_IDLE) || (state_q == ST_ARMED));
  assign wr_en       = capturing && rvfi_valid && !arm_restart;

  // Trigger select, evaluated combinationally on the retirement beat.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_TRAP:   trig_hit = rvfi_trap;
      TRIG_HALT:   trig_hit = rvfi_halt;
      TRIG_EITHER: trig_hit = rvfi_trap || rvfi_halt;
      TRIG_PC:     trig_hit = (rvfi_pc_rdata == trig_pc);
      default:     trig_hit = 1'b0;
    endcase
  end

  // Pack the retirement record.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_rec                       = '0;
    wr_rec[O_PCW +: PC_W]        = rvfi_pc_wdata;
    wr_rec[O_PCR +: PC_W]        = rvfi_pc_rdata;
    wr_rec[O_INSN +: INSN_W]     = rvfi_insn;
    wr_rec[O_ORDER +: ORDER_W]   = rvfi_order[ORDER_W-1:0];
    wr_rec[O_INTR]               = rvfi_intr;
    wr_rec[O_HALT]               = rvfi_halt;
    wr_rec[O_TRAP]               = rvfi_trap;
  end

  // Drain-side addressing: oldest record sits count entries behind wptr.
  assign remaining  = count - issued;
  assign rd_addr    = wptr - addr_t'(count) + addr_t'(issued);
  assign rd_fire    = (state_q == ST_DRAIN) && (remaining != '0) && (!out_valid || rd_ready);
  assign drain_done = out_valid && rd_ready && out_last;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (arm) begin
          state_d = ST_ARMED;
        end else if (rvfi_valid && trig_hit) begin
          if (POST_TRIG == 0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (rvfi_valid && (post_cnt == post_t'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((count == '0) || drain_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // History pointer, fill level, sticky flags and order tracking.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wptr       <= '0;
      count      <= '0;
      wrapped    <= 1'b0;
      order_gap  <= 1'b0;
      prev_valid <= 1'b0;
      prev_order <= '0;
    end else if (arm_restart) begin
      wptr       <= '0;
      count      <= '0;
      wrapped    <= 1'b0;
      order_gap  <= 1'b0;
      prev_valid <= 1'b0;
    end else if (wr_en) begin
      wptr <= wptr + addr_t'(1);
      if (count == FULL) begin
        wrapped <= 1'b1;
      end else begin
        count <= count + cnt_t'(1);
      end
      if (prev_valid && (rvfi_order != prev_order + 64'd1)) begin
        order_gap <= 1'b1;
      end
      prev_order <= rvfi_order;
      prev_valid <= 1'b1;
    end
  end

  // Post-trigger countdown.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      post_cnt <= '0;
    end else if ((state_q == ST_ARMED) && (state_d == ST_POST)) begin
      post_cnt <= post_t'(POST_TRIG);
    end else if ((state_q == ST_POST) && wr_en) begin
      post_cnt <= post_cnt - post_t'(1);
    end
  end

  // Drain stream: issue a RAM read whenever the output slot is empty or
  // being consumed, so a held-high rd_ready gets one record per cycle.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      issued    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (state_q != ST_DRAIN) begin
      issued    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (rd_fire) begin
      issued    <= issued + cnt_t'(1);
      out_valid <= 1'b1;
      out_last  <= (remaining == cnt_t'(1));
    end else if (out_valid && rd_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_ram (
    .clk   (sys_clock),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (wr_rec),
    .re    (rd_fire),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign state    = state_q;
  assign rd_valid = out_valid;
  assign rd_last  = out_last;
  assign rd_data  = out_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_rvfi_trace_capture.sv
// Self-checking bench: two tracer instances (POST_TRIG=2 and POST_TRIG=0)
// share stimulus; a queue model predicts the drained records of the selected one.
module tb_rvfi_trace_capture;

  localparam int DEPTH   = 8;
  localparam int PC_W    = 32;
  localparam int ORDER_W = 16;
  localparam int REC_W   = 3 + ORDER_W + 32 + 2 * PC_W;

  logic             sys_clock = 1'b0;
  logic             reset;
  logic             rvfi_valid;
  logic [63:0]      rvfi_order;
  logic [31:0]      rvfi_insn;
  logic             rvfi_trap;
  logic             rvfi_halt;
  logic             rvfi_intr;
  logic [PC_W-1:0]  rvfi_pc_rdata;
  logic [PC_W-1:0]  rvfi_pc_wdata;
  logic             arm;
  logic [1:0]       trig_mode;
  logic [PC_W-1:0]  trig_pc;
  logic             rd_ready;
  logic             sel;

  logic [1:0]       state_a,    state_b;
  logic             rd_valid_a, rd_valid_b;
  logic [REC_W-1:0] rd_data_a,  rd_data_b;
  logic             rd_last_a,  rd_last_b;
  logic             wrapped_a,  wrapped_b;
  logic             gap_a,      gap_b;
  logic             rd_ready_a, rd_ready_b;

  logic [1:0]       state_m;
  logic             rd_valid_m;
  logic [REC_W-1:0] rd_data_m;
  logic             rd_last_m;
  logic             wrapped_m;
  logic             gap_m;

  assign rd_ready_a = rd_ready && !sel;
  assign rd_ready_b = rd_ready && sel;
  assign state_m    = sel ? state_b    : state_a;
  assign rd_valid_m = sel ? rd_valid_b : rd_valid_a;
  assign rd_data_m  = sel ? rd_data_b  : rd_data_a;
  assign rd_last_m  = sel ? rd_last_b  : rd_last_a;
  assign wrapped_m  = sel ? wrapped_b  : wrapped_a;
  assign gap_m      = sel ? gap_b      : gap_a;

  always #5 sys_clock = ~sys_clock;

  rvfi_trace_capture #(
    .DEPTH(DEPTH), .PC_W(PC_W), .ORDER_W(ORDER_W), .POST_TRIG(2)
  ) u_dut (
    .sys_clock(sys_clock), .reset(reset), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .arm(arm), .trig_mode(trig_mode),
    .trig_pc(trig_pc), .state(state_a), .rd_valid(rd_valid_a),
    .rd_ready(rd_ready_a), .rd_data(rd_data_a), .rd_last(rd_last_a),
    .wrapped(wrapped_a), .order_gap(gap_a)
  );

  rvfi_trace_capture #(
    .DEPTH(DEPTH), .PC_W(PC_W), .ORDER_W(ORDER_W), .POST_TRIG(0)
  ) u_dut0 (
    .sys_clock(sys_clock), .reset(reset), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .arm(arm), .trig_mode(trig_mode),
    .trig_pc(trig_pc), .state(state_b), .rd_valid(rd_valid_b),
    .rd_ready(rd_ready_b), .rd_data(rd_data_b), .rd_last(rd_last_b),
    .wrapped(wrapped_b), .order_gap(gap_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the selected instance.
  logic [REC_W-1:0] exp_q[$];
  bit               m_cap;
  bit               m_post;
  int               m_post_cnt;
  bit               m_wrapped;
  bit               m_gap;
  bit               m_prev_v;
  logic [63:0]      m_prev;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input logic [63:0] order);
    return 32'h8000_0000 + {order[29:0], 2'b00};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_cap = 0; m_post = 0; m_post_cnt = 0;
    m_wrapped = 0; m_gap = 0; m_prev_v = 0; m_prev = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge sys_clock);
    @(negedge sys_clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(negedge sys_clock);
    arm = 1'b0;
    model_clear();
    m_cap = 1;
  endtask

  task automatic retire(input logic [63:0] order, input logic trap, input logic halt,
                        input logic [31:0] pc);
    logic [31:0] insn;
    logic        intr;
    bit          hit;
    int          pt;
    insn = 32'h0000_0013 ^ {order[24:0], 7'd0};
    intr = order[0] & ~trap;
    rvfi_valid = 1'b1; rvfi_order = order; rvfi_insn = insn;
    rvfi_trap = trap; rvfi_halt = halt; rvfi_intr = intr;
    rvfi_pc_rdata = pc; rvfi_pc_wdata = pc + 32'd4;
    if (m_cap) begin
      pt = sel ? 0 : 2;
      exp_q.push_back({trap, halt, intr, order[ORDER_W-1:0], insn, pc, pc + 32'd4});
      if (exp_q.size() > DEPTH) begin
        void'(exp_q.pop_front());
        m_wrapped = 1;
      end
      if (m_prev_v && order != m_prev + 64'd1) m_gap = 1;
      m_prev = order; m_prev_v = 1;
      case (trig_mode)
        2'd0:    hit = trap;
        2'd1:    hit = halt;
        2'd2:    hit = trap | halt;
        default: hit = (pc == trig_pc);
      endcase
      if (m_post) begin
        m_post_cnt--;
        if (m_post_cnt == 0) m_cap = 0;
      end else if (hit) begin
        if (pt == 0) m_cap = 0;
        else begin m_post = 1; m_post_cnt = pt; end
      end
    end
    @(negedge sys_clock);
    rvfi_valid = 1'b0; rvfi_trap = 1'b0; rvfi_halt = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_wrapped"}, 128'(wrapped_m), 128'(m_wrapped));
    check({tag, "_order_gap"}, 128'(gap_m), 128'(m_gap));
  endtask

  // Drain the selected instance; stall=1 applies a 1,0,0,1 rd_ready pattern.
  task automatic drain(input string tag, input bit stall);
    int n, first, last_c, c, wait_c;
    bit done, held, held_v;
    logic [REC_W-1:0] held_d, exp_d;
    n = exp_q.size(); first = -1; last_c = -1; done = 0; held = 0; held_v = 0;
    held_d = '0; wait_c = 0;
    while (state_m != 2'd3 && wait_c < 50) begin
      @(negedge sys_clock);
      wait_c++;
    end
    check({tag, "_enter_drain"}, 128'(state_m), 128'(3));
    c = 0;
    while (!done && c < 200) begin
      rd_ready = !stall || (c % 4 == 0) || (c % 4 == 3);
      if (held) begin
        check({tag, "_stall_valid"}, 128'(rd_valid_m), 128'(held_v));
        check({tag, "_stall_data"}, 128'(rd_data_m), 128'(held_d));
      end
      if (rd_valid_m && first < 0) first = c;
      if (rd_valid_m && rd_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_record"}, 128'(1), 128'(0));
        end else begin
          exp_d = exp_q.pop_front();
          check({tag, "_data"}, 128'(rd_data_m), 128'(exp_d));
          check({tag, "_last"}, 128'(rd_last_m), 128'(exp_q.size() == 0));
          if (exp_q.size() == 0) begin
            done = 1;
            last_c = c;
          end
        end
      end
      held   = rd_valid_m && !rd_ready;
      held_v = rd_valid_m;
      held_d = rd_data_m;
      @(negedge sys_clock);
      c++;
    end
    rd_ready = 1'b0;
    if (!done) check({tag, "_drain_timeout"}, 128'(0), 128'(1));
    check({tag, "_first_latency_ok"}, 128'(first >= 0 && first <= 2), 128'(1));
    if (!stall) check({tag, "_full_rate_cycles"}, 128'(last_c - first + 1), 128'(n));
    check({tag, "_post_valid"}, 128'(rd_valid_m), 128'(0));
    check({tag, "_post_state"}, 128'(state_m), 128'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rvfi_valid = 1'b0; rvfi_order = '0; rvfi_insn = '0;
    rvfi_trap = 1'b0; rvfi_halt = 1'b0; rvfi_intr = 1'b0;
    rvfi_pc_rdata = '0; rvfi_pc_wdata = '0; arm = 1'b0; trig_mode = 2'd0;
    trig_pc = '0; rd_ready = 1'b0; sel = 1'b0;
    model_clear();
    @(negedge sys_clock);
    do_reset();

    // Reset values.
    check("rst_state",    128'(state_m),    128'(0));
    check("rst_rd_valid", 128'(rd_valid_m), 128'(0));
    check("rst_rd_last",  128'(rd_last_m),  128'(0));
    check("rst_rd_data",  128'(rd_data_m),  128'(0));
    check("rst_wrapped",  128'(wrapped_m),  128'(0));
    check("rst_gap",      128'(gap_m),      128'(0));

    // Trap trigger, two post-trigger retirements, no wrap.
    sel = 1'b0; trig_mode = 2'd0;
    do_arm();
    check("t1_armed", 128'(state_m), 128'(1));
    for (int i = 1; i <= 10; i++) retire(64'(i), i == 6, 1'b0, pc_of(64'(i)));
    check_flags("t1");
    check("t1_wrapped_const", 128'(wrapped_m), 128'(0));
    drain("t1", 1'b0);

    // Wrap with immediate freeze (POST_TRIG=0 instance), halt trigger.
    do_reset();
    sel = 1'b1; trig_mode = 2'd1;
    do_arm();
    for (int i = 1; i <= 20; i++) retire(64'(i), 1'b0, i == 20, pc_of(64'(i)));
    check_flags("t2");
    check("t2_wrapped_const", 128'(wrapped_m), 128'(1));
    check("t2_record_count", 128'(exp_q.size()), 128'(8));
    drain("t2", 1'b0);

    // Backpressure; orders cross the 64-bit wrap and must not flag a gap.
    do_reset();
    sel = 1'b0; trig_mode = 2'd2;
    do_arm();
    for (int i = 0; i < 9; i++) retire(64'hFFFF_FFFF_FFFF_FFFD + 64'(i), i == 4, 1'b0,
                                       pc_of(64'(i)));
    check_flags("t3");
    check("t3_gap_const", 128'(gap_m), 128'(0));
    drain("t3", 1'b1);

    // PC trigger with an order gap; trap must not trigger in PC mode.
    do_reset();
    sel = 1'b0; trig_mode = 2'd3; trig_pc = 32'h8000_0010;
    do_arm();
    retire(64'd1, 1'b0, 1'b0, pc_of(64'd1));
    retire(64'd2, 1'b1, 1'b0, pc_of(64'd2));
    retire(64'd4, 1'b0, 1'b0, pc_of(64'd4));
    retire(64'd5, 1'b0, 1'b0, pc_of(64'd5));
    check("t4_post_state", 128'(state_m), 128'(2));
    retire(64'd6, 1'b0, 1'b0, pc_of(64'd6));
    retire(64'd7, 1'b0, 1'b0, pc_of(64'd7));
    check_flags("t4");
    check("t4_gap_const", 128'(gap_m), 128'(1));
    drain("t4", 1'b0);

    // Reset mid-drain, then a fresh capture with no stale records.
    do_reset();
    sel = 1'b0; trig_mode = 2'd0;
    do_arm();
    retire(64'd10, 1'b0, 1'b0, pc_of(64'd10));
    for (int i = 12; i <= 22; i++) retire(64'(i), i == 20, 1'b0, pc_of(64'(i)));
    check_flags("t5");
    check("t5_in_drain", 128'(state_m), 128'(3));
    rd_ready = 1'b1;
    @(negedge sys_clock);
    @(negedge sys_clock);
    rd_ready = 1'b0;
    reset = 1'b1;
    @(negedge sys_clock);
    reset = 1'b0;
    model_clear();
    check("t5_rst_state",    128'(state_m),    128'(0));
    check("t5_rst_rd_valid", 128'(rd_valid_m), 128'(0));
    check("t5_rst_rd_last",  128'(rd_last_m),  128'(0));
    check("t5_rst_wrapped",  128'(wrapped_m),  128'(0));
    check("t5_rst_gap",      128'(gap_m),      128'(0));
    retire(64'd50, 1'b1, 1'b0, pc_of(64'd50));
    check("t5_idle_ignores", 128'(state_m), 128'(0));
    do_arm();
    for (int i = 100; i <= 103; i++) retire(64'(i), i == 100, 1'b0, pc_of(64'(i)));
    check_flags("t5b");
    drain("t5b", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
